// File: rtl/svm_sched_pkg.sv
// rtl/svm_sched_pkg.sv - shared types and conflict rule for the SVM lane dispatcher
package svm_sched_pkg;

   localparam int MAX_DEPS_DEFAULT = 1024;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      CHECK    = 2'd1,
      DISPATCH = 2'd2
   } state_e;

   typedef struct packed {
      logic [63:0]                 owner_programID;
      logic [MAX_DEPS_DEFAULT-1:0] read_deps;
      logic [MAX_DEPS_DEFAULT-1:0] write_deps;
   } svm_txn_t;

   // WAW/WAR on the head's write set, RAW on its read set; read-read sharing is allowed
   function automatic logic has_conflict(input logic [MAX_DEPS_DEFAULT-1:0] head_r,
                                         input logic [MAX_DEPS_DEFAULT-1:0] head_w,
                                         input logic [MAX_DEPS_DEFAULT-1:0] lr,
                                         input logic [MAX_DEPS_DEFAULT-1:0] lw);
      return (|(head_w & (lr | lw))) | (|(head_r & lw));
   endfunction

endpackage

// File: rtl/svm_rr_lane_picker.sv
// rtl/svm_rr_lane_picker.sv - combinational round-robin search for a free lane
module svm_rr_lane_picker #(
   parameter int NUM_LANES = 4,
   parameter int IDXW      = $clog2(NUM_LANES)
) (
   input  logic [NUM_LANES-1:0] free_i,
   input  logic [IDXW-1:0]      rr_ptr_i,
   output logic                 found_o,
   output logic [NUM_LANES-1:0] sel_onehot_o,
   output logic [IDXW-1:0]      sel_idx_o
);

   logic [IDXW:0]   sum;
   logic [IDXW-1:0] pos;

   always_comb begin
      found_o      = 1'b0;
      sel_onehot_o = '0;
      sel_idx_o    = '0;
      sum          = '0;
      pos          = '0;
      for (int k = 0; k < NUM_LANES; k++) begin
         sum = {1'b0, rr_ptr_i} + (IDXW+1)'(k);
         if (sum >= (IDXW+1)'(NUM_LANES)) sum = sum - (IDXW+1)'(NUM_LANES);
         pos = sum[IDXW-1:0];
         if (!found_o && free_i[pos]) begin
            found_o           = 1'b1;
            sel_onehot_o[pos] = 1'b1;
            sel_idx_o         = pos;
         end
      end
   end

endmodule

// File: rtl/svm_lane_dispatcher.sv
// rtl/svm_lane_dispatcher.sv - issues scheduler transactions to lanes with dependency locking
module svm_lane_dispatcher
   import svm_sched_pkg::*;
#(
   parameter int MAX_DEPENDENCIES = MAX_DEPS_DEFAULT,
   parameter int NUM_LANES        = 4
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        s_axis_tvalid,
   output logic                        s_axis_tready,
   input  logic [63:0]                 s_axis_tdata_owner_programID,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_read_dependencies,
   input  logic [MAX_DEPENDENCIES-1:0] s_axis_tdata_write_dependencies,
   output logic [NUM_LANES-1:0]        m_lane_valid,
   input  logic [NUM_LANES-1:0]        m_lane_ready,
   output logic [63:0]                 m_lane_owner_programID,
   output logic [MAX_DEPENDENCIES-1:0] m_lane_read_dependencies,
   output logic [MAX_DEPENDENCIES-1:0] m_lane_write_dependencies,
   input  logic [NUM_LANES-1:0]        lane_done,
   output logic [NUM_LANES-1:0]        lanes_busy,
   output logic [31:0]                 conflict_stalls,
   output logic [31:0]                 dispatched_count
);

   localparam int IDXW = $clog2(NUM_LANES);

   state_e                      state_q, state_d;
   svm_txn_t                    head_q, head_d;
   logic [NUM_LANES-1:0]        busy_q, busy_d;
   logic [MAX_DEPENDENCIES-1:0] lock_r_q [NUM_LANES];
   logic [MAX_DEPENDENCIES-1:0] lock_w_q [NUM_LANES];
   logic [MAX_DEPENDENCIES-1:0] lock_r_d [NUM_LANES];
   logic [MAX_DEPENDENCIES-1:0] lock_w_d [NUM_LANES];
   logic [IDXW-1:0]             rr_ptr_q, rr_ptr_d, sel_idx_q, sel_idx_d;
   logic [NUM_LANES-1:0]        sel_oh_q, sel_oh_d;
   logic                        first_check_q, first_check_d;
   logic [31:0]                 stalls_q, stalls_d, disp_q, disp_d;

   logic [MAX_DEPENDENCIES-1:0] agg_r, agg_w;
   logic                        conflict, found, in_hs, out_acc;
   logic [NUM_LANES-1:0]        pick_oh;
   logic [IDXW-1:0]             pick_idx;

   svm_rr_lane_picker #(.NUM_LANES(NUM_LANES), .IDXW(IDXW)) u_picker (
      .free_i       (~busy_q),
      .rr_ptr_i     (rr_ptr_q),
      .found_o      (found),
      .sel_onehot_o (pick_oh),
      .sel_idx_o    (pick_idx)
   );

   // Aggregate locks come from registered state only, so a release shows up one cycle later
   always_comb begin
      agg_r = '0;
      agg_w = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         if (busy_q[i]) begin
            agg_r = agg_r | lock_r_q[i];
            agg_w = agg_w | lock_w_q[i];
         end
      end
   end

   assign conflict = has_conflict(head_q.read_deps, head_q.write_deps,
                                  MAX_DEPS_DEFAULT'(agg_r), MAX_DEPS_DEFAULT'(agg_w));
   assign in_hs    = (state_q == IDLE) && s_axis_tvalid;
   assign out_acc  = (state_q == DISPATCH) && |(m_lane_ready & sel_oh_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:     if (s_axis_tvalid) state_d = CHECK;
         CHECK:    if (!conflict && found) state_d = DISPATCH;
         DISPATCH: if (out_acc) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      s_axis_tready = (state_q == IDLE);
      m_lane_valid  = (state_q == DISPATCH) ? sel_oh_q : '0;
   end

   assign m_lane_owner_programID    = head_q.owner_programID;
   assign m_lane_read_dependencies  = head_q.read_deps[MAX_DEPENDENCIES-1:0];
   assign m_lane_write_dependencies = head_q.write_deps[MAX_DEPENDENCIES-1:0];
   assign lanes_busy                = busy_q;
   assign conflict_stalls           = stalls_q;
   assign dispatched_count          = disp_q;

   always_comb begin
      head_d        = head_q;
      sel_idx_d     = sel_idx_q;
      sel_oh_d      = sel_oh_q;
      first_check_d = first_check_q;
      stalls_d      = stalls_q;
      disp_d        = disp_q;
      rr_ptr_d      = rr_ptr_q;
      busy_d        = busy_q;
      lock_r_d      = lock_r_q;
      lock_w_d      = lock_w_q;
      if (in_hs) begin
         head_d.owner_programID = s_axis_tdata_owner_programID;
         head_d.read_deps       = MAX_DEPS_DEFAULT'(s_axis_tdata_read_dependencies);
         head_d.write_deps      = MAX_DEPS_DEFAULT'(s_axis_tdata_write_dependencies);
         first_check_d          = 1'b1;
      end
      if (state_q == CHECK) begin
         first_check_d = 1'b0;
         if (first_check_q && conflict) stalls_d = stalls_q + 32'd1;
         if (!conflict && found) begin
            sel_idx_d = pick_idx;
            sel_oh_d  = pick_oh;
         end
      end
      // Completion and a new dispatch never hit the same lane, so both apply
      for (int i = 0; i < NUM_LANES; i++) begin
         if (lane_done[i] && busy_q[i]) begin
            busy_d[i]   = 1'b0;
            lock_r_d[i] = '0;
            lock_w_d[i] = '0;
         end
         if (out_acc && sel_oh_q[i]) begin
            busy_d[i]   = 1'b1;
            lock_r_d[i] = head_q.read_deps[MAX_DEPENDENCIES-1:0];
            lock_w_d[i] = head_q.write_deps[MAX_DEPENDENCIES-1:0];
         end
      end
      if (out_acc) begin
         disp_d   = disp_q + 32'd1;
         rr_ptr_d = (sel_idx_q == IDXW'(NUM_LANES-1)) ? '0 : sel_idx_q + IDXW'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q        <= '0;
         sel_idx_q     <= '0;
         sel_oh_q      <= '0;
         first_check_q <= 1'b0;
         stalls_q      <= '0;
         disp_q        <= '0;
         rr_ptr_q      <= '0;
         busy_q        <= '0;
         for (int i = 0; i < NUM_LANES; i++) begin
            lock_r_q[i] <= '0;
            lock_w_q[i] <= '0;
         end
      end else begin
         head_q        <= head_d;
         sel_idx_q     <= sel_idx_d;
         sel_oh_q      <= sel_oh_d;
         first_check_q <= first_check_d;
         stalls_q      <= stalls_d;
         disp_q        <= disp_d;
         rr_ptr_q      <= rr_ptr_d;
         busy_q        <= busy_d;
         lock_r_q      <= lock_r_d;
         lock_w_q      <= lock_w_d;
      end
   end

endmodule

// File: tb/tb_svm_lane_dispatcher.sv
// tb/tb_svm_lane_dispatcher.sv - directed scoreboard bench for svm_lane_dispatcher
module tb_svm_lane_dispatcher;

   localparam int MD = 1024;
   localparam int NL = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          s_axis_tvalid;
   logic          s_axis_tready;
   logic [63:0]   s_id;
   logic [MD-1:0] s_r, s_w;
   logic [NL-1:0] m_lane_valid, m_lane_ready, lane_done, lanes_busy;
   logic [63:0]   m_id;
   logic [MD-1:0] m_r, m_w;
   logic [31:0]   conflict_stalls, dispatched_count;

   typedef struct {
      logic [63:0]   id;
      logic [NL-1:0] lane_oh;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   checks = 0;
   int   errors = 0;

   svm_lane_dispatcher #(.MAX_DEPENDENCIES(MD), .NUM_LANES(NL)) dut (
      .clk                             (clk),
      .rst_n                           (rst_n),
      .s_axis_tvalid                   (s_axis_tvalid),
      .s_axis_tready                   (s_axis_tready),
      .s_axis_tdata_owner_programID    (s_id),
      .s_axis_tdata_read_dependencies  (s_r),
      .s_axis_tdata_write_dependencies (s_w),
      .m_lane_valid                    (m_lane_valid),
      .m_lane_ready                    (m_lane_ready),
      .m_lane_owner_programID          (m_id),
      .m_lane_read_dependencies        (m_r),
      .m_lane_write_dependencies       (m_w),
      .lane_done                       (lane_done),
      .lanes_busy                      (lanes_busy),
      .conflict_stalls                 (conflict_stalls),
      .dispatched_count                (dispatched_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Every accepted dispatch must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (rst_n && (m_lane_valid & m_lane_ready) != '0) begin
         if (sb.size() == 0) begin
            check("unexpected_dispatch", {60'b0, m_lane_valid}, 64'h0);
         end else begin
            mon_e = sb.pop_front();
            check("dispatch_lane", {60'b0, m_lane_valid}, {60'b0, mon_e.lane_oh});
            check("dispatch_id", m_id, mon_e.id);
         end
      end
   end

   task automatic do_reset();
      rst_n         = 1'b0;
      s_axis_tvalid = 1'b0;
      s_id          = '0;
      s_r           = '0;
      s_w           = '0;
      m_lane_ready  = '1;
      lane_done     = '0;
      sb.delete();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic send(input logic [63:0] id, input logic [MD-1:0] r, input logic [MD-1:0] w,
                       input int lane);
      exp_t e;
      bit   done;
      e.id      = id;
      e.lane_oh = NL'(1 << lane);
      sb.push_back(e);
      s_axis_tvalid = 1'b1;
      s_id = id;
      s_r  = r;
      s_w  = w;
      done = 1'b0;
      for (int n = 0; n < 200 && !done; n++) begin
         if (s_axis_tready) done = 1'b1;
         @(posedge clk);
         #1;
      end
      s_axis_tvalid = 1'b0;
      check("send_handshake", {63'b0, done}, 64'h1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(posedge clk);
         n++;
      end
      #1;
      check("drain_empty", 64'(sb.size()), 64'h0);
   endtask

   task automatic pulse_done(input logic [NL-1:0] m);
      lane_done = m;
      @(posedge clk);
      #1 lane_done = '0;
   endtask

   logic [63:0]   t2_ida [3] = '{64'h11, 64'h4, 64'h14};
   logic [63:0]   t2_idb [3] = '{64'h12, 64'h5, 64'h15};
   logic [63:0]   t2_ra  [3] = '{64'h0, 64'h0, 64'h1000};
   logic [63:0]   t2_wa  [3] = '{64'h400, 64'h40, 64'h0};
   logic [63:0]   t2_rb  [3] = '{64'h0, 64'h40, 64'h0};
   logic [63:0]   t2_wb  [3] = '{64'h400, 64'h0, 64'h1000};
   logic [2*MD+63:0] snap;

   initial begin
      #200000;
      $display("FAIL global_timeout");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_tready", {63'b0, s_axis_tready}, 64'h1);
      check("rst_valid", {60'b0, m_lane_valid}, 64'h0);
      check("rst_busy", {60'b0, lanes_busy}, 64'h0);
      check("rst_disp", {32'b0, dispatched_count}, 64'h0);
      check("rst_stalls", {32'b0, conflict_stalls}, 64'h0);
      check("rst_bus_id", m_id, 64'h0);

      // T1: two independent transactions, first-dispatch latency
      @(posedge clk); #1;
      send(64'h1, MD'(64'h1), MD'(64'h2), 0);
      @(negedge clk);
      check("t1_valid_t1", {60'b0, m_lane_valid}, 64'h0);
      @(negedge clk);
      check("t1_valid_t2", {60'b0, m_lane_valid}, 64'h1);
      send(64'h2, MD'(64'h4), MD'(64'h8), 1);
      drain();
      check("t1_busy", {60'b0, lanes_busy}, 64'h3);
      check("t1_disp", {32'b0, dispatched_count}, 64'h2);
      check("t1_stalls", {32'b0, conflict_stalls}, 64'h0);

      // T2: WAW, RAW, WAR hazards each hold the second transaction until lane 0 completes
      for (int c = 0; c < 3; c++) begin
         do_reset();
         send(t2_ida[c], MD'(t2_ra[c]), MD'(t2_wa[c]), 0);
         send(t2_idb[c], MD'(t2_rb[c]), MD'(t2_wb[c]), 1);
         repeat (5) @(posedge clk);
         #1;
         check($sformatf("t2_%0d_hold_tready", c), {63'b0, s_axis_tready}, 64'h0);
         check($sformatf("t2_%0d_hold_valid", c), {60'b0, m_lane_valid}, 64'h0);
         pulse_done(4'b0001);
         @(posedge clk);
         @(negedge clk);
         check($sformatf("t2_%0d_release_valid", c), {60'b0, m_lane_valid}, 64'h2);
         drain();
         check($sformatf("t2_%0d_stalls", c), {32'b0, conflict_stalls}, 64'h1);
         check($sformatf("t2_%0d_busy", c), {60'b0, lanes_busy}, 64'h2);
      end

      // T3: shared read sets do not conflict
      do_reset();
      send(64'h5, MD'(64'h40), MD'(64'h0), 0);
      send(64'h6, MD'(64'h40), MD'(64'h0), 1);
      drain();
      check("t3_stalls", {32'b0, conflict_stalls}, 64'h0);
      check("t3_busy", {60'b0, lanes_busy}, 64'h3);

      // T4: full lanes stall without counting, round-robin resumes after lane 2
      do_reset();
      for (int k = 0; k < 4; k++)
         send(64'h21 + 64'(k), MD'(64'h1) << (2*k), MD'(64'h2) << (2*k), k);
      drain();
      check("t4_busy_full", {60'b0, lanes_busy}, 64'hf);
      send(64'h25, MD'(64'h400), MD'(64'h800), 2);
      repeat (5) @(posedge clk);
      #1;
      check("t4_full_valid", {60'b0, m_lane_valid}, 64'h0);
      check("t4_full_stalls", {32'b0, conflict_stalls}, 64'h0);
      pulse_done(4'b0100);
      drain();
      check("t4_busy_refill", {60'b0, lanes_busy}, 64'hf);
      check("t4_disp", {32'b0, dispatched_count}, 64'h5);
      pulse_done(4'b1001);
      send(64'h26, MD'(64'h1000), MD'(64'h2000), 3);
      drain();
      check("t4_busy_rr", {60'b0, lanes_busy}, 64'he);

      // T5: backpressure on lane 0; other lanes' ready is ignored
      do_reset();
      m_lane_ready = 4'b0000;
      send(64'h31, MD'(64'hAA), MD'(64'h55), 0);
      @(negedge clk);
      @(negedge clk);
      snap = {m_id, m_r, m_w};
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         check("t5_valid_held", {60'b0, m_lane_valid}, 64'h1);
         check("t5_bus_stable", {63'b0, ({m_id, m_r, m_w} == snap)}, 64'h1);
      end
      @(posedge clk); #1;
      m_lane_ready = 4'b1110;
      @(negedge clk);
      check("t5_other_ready_ignored", {60'b0, m_lane_valid}, 64'h1);
      @(posedge clk); #1;
      m_lane_ready = 4'b1111;
      drain();
      check("t5_disp", {32'b0, dispatched_count}, 64'h1);
      check("t5_busy", {60'b0, lanes_busy}, 64'h1);

      // T6: asynchronous reset while a dispatch is pending
      do_reset();
      send(64'h40, MD'(64'h1), MD'(64'h2), 0);
      drain();
      m_lane_ready = 4'b0000;
      send(64'h41, MD'(64'h4), MD'(64'h8), 1);
      @(negedge clk);
      @(negedge clk);
      check("t6_valid_pending", {60'b0, m_lane_valid}, 64'h2);
      #2 rst_n = 1'b0;
      #1;
      check("t6_rst_valid", {60'b0, m_lane_valid}, 64'h0);
      check("t6_rst_busy", {60'b0, lanes_busy}, 64'h0);
      sb.delete();
      m_lane_ready = 4'b1111;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      check("t6_tready", {63'b0, s_axis_tready}, 64'h1);
      check("t6_disp", {32'b0, dispatched_count}, 64'h0);
      check("t6_stalls", {32'b0, conflict_stalls}, 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/svm_lane_dispatcher.md
Name: svm_lane_dispatcher

Overview:
Sits downstream of the SVM scheduler batch output and feeds transactions to NUM_LANES parallel execution lanes. Each dispatched transaction's read/write dependency sets stay locked while its lane is busy. A new transaction is issued only when it has no RAW/WAW/WAR conflict with any in-flight transaction and a lane is free. Lanes are chosen round-robin. The lock is released when the lane signals completion.

Parameters:
MAX_DEPENDENCIES, 1024, width of read/write dependency bitmaps
NUM_LANES, 4, number of execution lanes (2..8)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
s_axis_tvalid  input  1  input transaction valid
s_axis_tready  output  1  input ready
s_axis_tdata_owner_programID  input  64  transaction owner ID
s_axis_tdata_read_dependencies  input  MAX_DEPENDENCIES  read set bitmap
s_axis_tdata_write_dependencies  input  MAX_DEPENDENCIES  write set bitmap
m_lane_valid  output  NUM_LANES  one-hot dispatch valid
m_lane_ready  input  NUM_LANES  per-lane accept
m_lane_owner_programID  output  64  shared dispatch bus, qualified by m_lane_valid
m_lane_read_dependencies  output  MAX_DEPENDENCIES  shared dispatch bus
m_lane_write_dependencies  output  MAX_DEPENDENCIES  shared dispatch bus
lane_done  input  NUM_LANES  one-cycle completion pulse per lane
lanes_busy  output  NUM_LANES  busy flag per lane
conflict_stalls  output  32  transactions that hit at least one conflict
dispatched_count  output  32  transactions dispatched

Behaviour:
- One clock, clk. Asynchronous, active-low reset on rst_n.
- Reset values:
  - State = IDLE.
  - All outputs 0, except s_axis_tready = 1 after reset release.
  - busy, per-lane locks, rr_ptr, head register and counters all cleared.
- Per-lane state: busy[i], lock_r[i], lock_w[i].
- Aggregate locks: LR = OR of lock_r[i] over busy lanes; LW = OR of lock_w[i] over busy lanes. Both are computed from registered state only.
- FSM IDLE:
  - s_axis_tready = 1.
  - On handshake, capture ID/read/write into the head register and go to CHECK.
- FSM CHECK:
  - s_axis_tready = 0.
  - conflict = |(head_w & (LR | LW)) | |(head_r & LW).
  - free = ~busy.
  - If !conflict and free != 0: sel = first free lane searching upward from rr_ptr, wrapping modulo NUM_LANES; go to DISPATCH.
  - Else stay in CHECK. If conflict on this transaction's first CHECK cycle, increment conflict_stalls once; stalls caused only by full lanes are not counted.
- FSM DISPATCH:
  - m_lane_valid = one-hot(sel); bus carries the head register.
  - Valid and data are held stable until m_lane_ready[sel]. Ready bits of other lanes are ignored.
  - On accept: busy[sel] = 1, lock_r/lock_w[sel] = head sets, dispatched_count++, rr_ptr = (sel + 1) mod NUM_LANES, go to IDLE.
- Latency: accept at cycle t → CHECK at t+1 → m_lane_valid at t+2 at the earliest. Throughput is at most 1 transaction per 3 cycles.
- lane_done[i] with busy[i] = 1:
  - Clears busy[i] and both locks at the next edge.
  - The release is visible to CHECK one cycle later.
  - lane_done on an idle lane is ignored.
  - Multiple lane_done bits in the same cycle are all honoured.
- Simultaneous events: a lane_done and a DISPATCH accept in the same cycle never target the same lane, because sel is always a free lane. Both updates apply.
- An overlap between a transaction's own read and write sets is not a conflict.
- All-zero dependency sets never conflict; such a transaction waits only for a free lane.
- Counters wrap at 2^32.
- Reset mid-operation: in-flight lanes and the held transaction are discarded and m_lane_valid drops immediately. Lanes must be reset externally alongside this block.

Decomposition:
- Package svm_sched_pkg:
  - MAX_DEPENDENCIES default.
  - State enum {IDLE, CHECK, DISPATCH}.
  - Transaction struct {owner_programID, read_deps, write_deps}.
  - Conflict-check function.
- Sub-module svm_rr_lane_picker: inputs free mask and rr_ptr; outputs found and one-hot/index sel. Purely combinational.

Test Plan:
- T1: IDs 0x1 (r=0x1, w=0x2) and 0x2 (r=0x4, w=0x8), no lane_done, m_lane_ready all 1 → ID 0x1 on lane 0 and ID 0x2 on lane 1; first m_lane_valid 2 cycles after handshake; lanes_busy = 4'b0011, dispatched_count = 2, conflict_stalls = 0.
- T2 WAW/RAW/WAR, each run after a reset:
  - 0x11 w=0x400, then 0x12 w=0x400 → 0x12 holds in CHECK with s_axis_tready = 0.
  - Pulse lane_done[0] → 0x12 dispatches on lane 1 within 2 cycles; conflict_stalls = 1.
  - Repeat with 0x4 w=0x40 vs 0x5 r=0x40, and 0x14 r=0x1000 vs 0x15 w=0x1000 → same result in each case.
- T3 read-read sharing: 0x5 r=0x40 and 0x6 r=0x40 → both dispatch back-to-back on lanes 0 and 1; conflict_stalls = 0.
- T4 lanes full:
  - Four disjoint transactions fill the lanes (lanes_busy = 4'b1111); a fifth disjoint transaction stalls with conflict_stalls unchanged.
  - lane_done[2] → fifth transaction goes to lane 2; rr_ptr = 3.
- T5 backpressure: m_lane_ready[0] = 0 for 5 cycles → m_lane_valid[0] and all bus bits stable; dispatch completes on the first ready cycle.
- T6 reset mid-DISPATCH: assert rst_n = 0 → m_lane_valid = 0 asynchronously and lanes_busy = 0; after release, s_axis_tready = 1 and counters = 0.
